adc_acq_sequencer: RTL
======================

// Module: adc_acq_sequencer
// PURPOSE
//  Acquisition controller between the ADC config/trigger logic and the SPI ADC engine's AXIS command input.
//  Issues a conversion command per trigger pulse for a programmed number of samples (or continuously).
//  Shares the single command stream with software commands from the config block's AXIS output.
//  Reports busy/done/overrun and counters for the config status word.
// PARAMETERS
//  CMD_WIDTH  32  width of command words (s_axis_sw, m_axis, conv_cmd)
//  CNT_WIDTH  32  width of sample_count and conv_cnt
//  OVR_WIDTH  16  width of overrun_cnt (saturating)
// PORTS
//  aclk              in   1          clock
//  aresetn           in   1          reset, asynchronous, active-low
//  enable            in   1          level; rising edge arms an acquisition, low aborts/clears
//  continuous        in   1          1: ignore sample_count, run until enable low
//  sample_count      in   CNT_WIDTH  conversions per acquisition (sampled at arm)
//  conv_cmd          in   CMD_WIDTH  command word sent per conversion (sampled at load)
//  trigger           in   1          single-cycle conversion request pulse
//  s_axis_sw_tdata   in   CMD_WIDTH  software command
//  s_axis_sw_tvalid  in   1          software command valid
//  s_axis_sw_tready  out  1          software command accepted
//  m_axis_tdata      out  CMD_WIDTH  command to SPI engine
//  m_axis_tvalid     out  1          command valid
//  m_axis_tready     in   1          SPI engine ready
//  busy              out  1          state ARMED
//  done              out  1          state DONE
//  overrun           out  1          sticky: trigger dropped this acquisition
//  conv_cnt          out  CNT_WIDTH  conversion beats handshaken this acquisition
//  overrun_cnt       out  OVR_WIDTH  dropped triggers, saturating
// BEHAVIOUR
//  Reset: state IDLE; m_axis_tvalid/tdata, busy, done, overrun, conv_cnt, overrun_cnt, pending, owner all 0.
//  States IDLE/ARMED/DONE; enable_d registered copy of enable for edge detect.
//  IDLE: enable&&!enable_d -> ARMED, latch sample_count, clear conv_cnt/overrun/overrun_cnt/pending;
//   if !continuous && sample_count==0 -> DONE directly, no commands issued.
//  ARMED: trigger -> conversion request (conv_req = trigger || pending). DONE: done=1 until enable low.
//  enable low in ARMED/DONE -> IDLE next cycle; pending dropped; done/busy clear.
//  Triggers in IDLE/DONE and in the arming cycle are ignored, no overrun.
//  Output register: slot_free = !m_axis_tvalid || m_axis_tready. Once loaded, tdata/tvalid held until tready.
//  Priority on load: conv_req (ARMED only) > software. Loaded beat tagged owner=CONV/SW.
//  s_axis_sw_tready = slot_free && !(state==ARMED && conv_req) (comb.); sw passthrough allowed in every state.
//  Latency: trigger at cycle N with slot free -> m_axis_tvalid=1, tdata=conv_cmd at N+1.
//  Trigger with slot busy -> pending=1; pending clears when conversion loaded.
//  Trigger with pending already 1 -> dropped, overrun=1, overrun_cnt+1 (saturates at all-ones).
//  conv_cnt increments on m_axis handshake with owner=CONV; wraps in continuous mode.
//  !continuous and handshake making conv_cnt==sample_count -> DONE same edge; later triggers ignored.
//  Abort with beat already presented: beat stays valid until accepted (AXIS rule), counted only if in ARMED.
//  Async reset mid-beat: tvalid drops immediately; beat lost by design.
// TESTING
//  1 sample_count=3, cont=0, arm, 3 triggers 10 cyc apart, tready=1 -> 3 conv_cmd beats each 1 cyc after trigger, conv_cnt 1,2,3, done=1, busy=0.
//  2 tready=0, 3 triggers -> beat held, pending=1, overrun=1, overrun_cnt=1; tready=1 -> exactly 2 conv beats.
//  3 sw 0xA5A5_0001 valid same cycle as trigger -> conv beat first, sw_tready=0 that cycle, sw beat next.
//  4 cont=1, sample_count=2, 5 triggers -> 5 conv beats, conv_cnt=5, done stays 0.
//  5 enable low with beat held and pending=1 -> IDLE next cycle, held beat completes, no further conv beats, done=0.
//  6 sample_count=0, cont=0, arm -> done=1 one cycle after rising edge; trigger produces no beat; sw beats still pass.

Source files
------------

// File: rtl/adc_acq_sequencer.sv
// adc_acq_sequencer: arms on enable, turns trigger pulses into conversion commands and
// shares the single AXIS command stream with software commands.
module adc_acq_sequencer #(
  parameter int CMD_WIDTH = 32,
  parameter int CNT_WIDTH = 32,
  parameter int OVR_WIDTH = 16
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 enable,
  input  logic                 continuous,
  input  logic [CNT_WIDTH-1:0] sample_count,
  input  logic [CMD_WIDTH-1:0] conv_cmd,
  input  logic                 trigger,
  input  logic [CMD_WIDTH-1:0] s_axis_sw_tdata,
  input  logic                 s_axis_sw_tvalid,
  output logic                 s_axis_sw_tready,
  output logic [CMD_WIDTH-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 busy,
  output logic                 done,
  output logic                 overrun,
  output logic [CNT_WIDTH-1:0] conv_cnt,
  output logic [OVR_WIDTH-1:0] overrun_cnt
);
  typedef enum logic [1:0] {IDLE, ARMED, DONE} state_t;
  state_t state, state_n;
  logic enable_d, pending, owner;
  logic [CNT_WIDTH-1:0] sample_cnt_q;
  logic arm, armed, conv_req, slot_free, load_conv, load_sw, conv_hs, last_beat, drop;
  always_comb begin
    arm = state == IDLE && enable && !enable_d;
    armed = state == ARMED;
    conv_req = trigger || pending;
    slot_free = !m_axis_tvalid || m_axis_tready;
    load_conv = armed && conv_req && slot_free;
    s_axis_sw_tready = slot_free && !(armed && conv_req);
    load_sw = s_axis_sw_tready && s_axis_sw_tvalid;
    conv_hs = m_axis_tvalid && m_axis_tready && owner && armed;
    last_beat = conv_hs && !continuous && conv_cnt + CNT_WIDTH'(1) == sample_cnt_q;
    drop = armed && trigger && pending && !slot_free;
    state_n = (state != IDLE && !enable) ? IDLE :
              arm ? ((!continuous && sample_count == '0) ? DONE : ARMED) :
              last_beat ? DONE : state;
    busy = armed;
    done = state == DONE;
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
      enable_d <= 1'b0;
      pending <= 1'b0;
      owner <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata <= '0;
      overrun <= 1'b0;
      overrun_cnt <= '0;
      conv_cnt <= '0;
      sample_cnt_q <= '0;
    end else begin
      state <= state_n;
      enable_d <= enable;
      if (load_conv || load_sw) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata <= load_conv ? conv_cmd : s_axis_sw_tdata;
        owner <= load_conv;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      // one request may wait behind a held beat; a second one is dropped
      pending <= armed && state_n == ARMED && ((pending && trigger) || (conv_req && !slot_free));
      if (arm) begin
        sample_cnt_q <= sample_count;
        conv_cnt <= '0;
        overrun <= 1'b0;
        overrun_cnt <= '0;
      end else begin
        if (conv_hs) conv_cnt <= conv_cnt + CNT_WIDTH'(1);
        if (drop) begin
          overrun <= 1'b1;
          if (overrun_cnt != '1) overrun_cnt <= overrun_cnt + OVR_WIDTH'(1);
        end
      end
    end
  end
endmodule
